// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
//   entry_t : one shadow-pipeline slot {v, waddr, load}
//   ZERO    : architectural $0, never tracked
//   HZ_SEL_RF : forward-select value meaning "use the register file"
package hazard_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO = '0;
  localparam int HZ_SEL_RF = 0;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] waddr;
    logic             load;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam entry_t BUBBLE = '0;

  // Saturating increment for the stall-cycle counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Bundle of ID-stage signals exchanged with the hazard scoreboard.
//   master : ID stage / environment (drives instruction info, RF reads, stage results)
//   slave  : scoreboard (returns forwarded operands, selects, stall, stall counter)
interface hazard_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 3
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic                         hold;
  logic                         flush;
  logic                         id_valid;
  logic [4:0]                   id_rs_addr;
  logic [4:0]                   id_rt_addr;
  logic                         id_rs_used;
  logic                         id_rt_used;
  logic                         id_we;
  logic [4:0]                   id_waddr;
  logic                         id_is_load;
  logic [DATA_W-1:0]            rf_rs_data;
  logic [DATA_W-1:0]            rf_rt_data;
  logic [NUM_STAGES*DATA_W-1:0] stage_data;
  logic [DATA_W-1:0]            rs_data;
  logic [DATA_W-1:0]            rt_data;
  logic [SEL_W-1:0]             fwd_rs_sel;
  logic [SEL_W-1:0]             fwd_rt_sel;
  logic                         stall;
  logic [31:0]                  stall_cnt;

  modport master (
    output hold, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_we, id_waddr, id_is_load, rf_rs_data, rf_rt_data, stage_data,
    input  rs_data, rt_data, fwd_rs_sel, fwd_rt_sel, stall, stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_we, id_waddr, id_is_load, rf_rs_data, rf_rt_data, stage_data,
    output rs_data, rt_data, fwd_rs_sel, fwd_rt_sel, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_operand_match.sv
// Youngest-producer search for one source operand.
//   addr/used  : operand register index and whether it is read
//   entries    : shadow pipeline, index 0 = EX (youngest)
//   stage_data : per-stage results, stage k at [k*DATA_W +: DATA_W]
//   rf_data    : register-file value used when nothing matches
//   match      : some in-flight writer targets this operand
//   ready      : youngest matching writer already has its data
//   sel/data   : 0/RF when no match, k+1/stage_data[k] for the youngest match
module hazard_operand_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_W-1:0]             addr,
  input  logic                         used,
  input  entry_t [NUM_STAGES-1:0]      entries,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  input  logic [DATA_W-1:0]            rf_data,
  output logic                         match,
  output logic                         ready,
  output logic [SEL_W-1:0]             sel,
  output logic [DATA_W-1:0]            data
);

  logic [NUM_STAGES-1:0] hit;
  logic [NUM_STAGES-1:0] ok;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_entry
      assign hit[gi] = used && (addr != ZERO) && entries[gi].v && (entries[gi].waddr == addr);
      // Load data only exists from stage LOAD_LAT onward.
      assign ok[gi]  = !entries[gi].load || (gi >= LOAD_LAT);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index has the final say.
  always_comb begin
    match = 1'b0;
    ready = 1'b1;
    sel   = SEL_W'(HZ_SEL_RF);
    data  = rf_data;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        match = 1'b1;
        ready = ok[k];
        sel   = SEL_W'(k + 1);
        data  = stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding/interlock unit for the ID stage, generalised to NUM_STAGES
// downstream stages.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard_if slave port (instruction info in, forwarded operands,
//           selects, stall and saturating stall counter out)
// State is only the shadow pipeline of in-flight writers and stall_cnt;
// all outputs are combinational from that state and the current inputs.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  entry_t [NUM_STAGES-1:0] entries_reg;
  entry_t [NUM_STAGES-1:0] entries_next;
  logic [31:0]             stall_cnt_reg;

  logic rs_match, rs_ready, rt_match, rt_ready;
  logic stall;
  logic insert;

  hazard_operand_match #(
    .DATA_W(DATA_W), .NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_rs_match (
    .addr(bus.id_rs_addr), .used(bus.id_rs_used), .entries(entries_reg),
    .stage_data(bus.stage_data), .rf_data(bus.rf_rs_data),
    .match(rs_match), .ready(rs_ready), .sel(bus.fwd_rs_sel), .data(bus.rs_data)
  );

  hazard_operand_match #(
    .DATA_W(DATA_W), .NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_rt_match (
    .addr(bus.id_rt_addr), .used(bus.id_rt_used), .entries(entries_reg),
    .stage_data(bus.stage_data), .rf_data(bus.rf_rt_data),
    .match(rt_match), .ready(rt_ready), .sel(bus.fwd_rt_sel), .data(bus.rt_data)
  );

  assign stall = bus.id_valid && ((rs_match && !rs_ready) || (rt_match && !rt_ready));
  // The reads above used the pre-insert entries, so a self-dependent
  // instruction sees only older producers.
  assign insert = bus.id_valid && bus.id_we && (bus.id_waddr != ZERO) && !stall;

  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_reg;

  always_comb begin
    entries_next = entries_reg;
    if (!bus.hold) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        entries_next[k] = entries_reg[k-1];
      end
      if (bus.flush) begin
        // Kill both the instruction in ID and the one currently in EX.
        entries_next[0] = BUBBLE;
        entries_next[1] = BUBBLE;
      end else if (insert) begin
        entries_next[0] = '{v: 1'b1, waddr: bus.id_waddr, load: bus.id_is_load};
      end else begin
        entries_next[0] = BUBBLE;
      end
    end else if (bus.flush) begin
      // Pipeline frozen, but the EX instruction must still die.
      entries_next[0].v = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      entries_reg <= entries_next;
      if (stall && !bus.hold && !bus.flush) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int DW = 32;
  localparam int NS = 3;
  localparam int LL = 1;
  localparam int SW = $clog2(NS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.DATA_W(DW), .NUM_STAGES(NS)) bus ();

  hazard_scoreboard #(.DATA_W(DW), .NUM_STAGES(NS), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: list of in-flight writers, position 0 = youngest (EX).
  logic        m_v [NS];
  logic [4:0]  m_w [NS];
  logic        m_l [NS];
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest in-flight writer of addr decides forwarding; it blocks if it is
  // a load that has not reached the stage where memory data appears.
  function automatic void ref_operand(input logic used, input logic [4:0] addr,
                                      input logic [31:0] rf, output logic [SW-1:0] sel,
                                      output logic [31:0] data, output logic blocked);
    logic found;
    found = 1'b0; sel = '0; data = rf; blocked = 1'b0;
    if (used && addr != 5'd0) begin
      for (int k = 0; k < NS; k++) begin
        if (!found && m_v[k] && m_w[k] == addr) begin
          found   = 1'b1;
          sel     = SW'(k + 1);
          data    = bus.stage_data[k*DW +: DW];
          blocked = m_l[k] && (k < LL);
        end
      end
    end
  endfunction

  function automatic logic ref_stall();
    logic [SW-1:0] s; logic [31:0] d; logic b_rs, b_rt;
    ref_operand(bus.id_rs_used, bus.id_rs_addr, bus.rf_rs_data, s, d, b_rs);
    ref_operand(bus.id_rt_used, bus.id_rt_addr, bus.rf_rt_data, s, d, b_rt);
    return bus.id_valid && (b_rs || b_rt);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        m_v[k] <= 1'b0; m_w[k] <= '0; m_l[k] <= 1'b0;
      end
      m_cnt <= '0;
    end else begin
      if (!bus.hold) begin
        for (int k = 1; k < NS; k++) begin
          m_v[k] <= m_v[k-1]; m_w[k] <= m_w[k-1]; m_l[k] <= m_l[k-1];
        end
        if (bus.flush) begin
          m_v[0] <= 1'b0; m_v[1] <= 1'b0;
        end else begin
          m_v[0] <= bus.id_valid && bus.id_we && bus.id_waddr != 5'd0 && !ref_stall();
          m_w[0] <= bus.id_waddr;
          m_l[0] <= bus.id_is_load;
        end
      end else if (bus.flush) begin
        m_v[0] <= 1'b0;
      end
      if (ref_stall() && !bus.hold && !bus.flush && m_cnt != 32'hFFFF_FFFF)
        m_cnt <= m_cnt + 32'd1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [SW-1:0] e_rs_sel, e_rt_sel;
    logic [31:0]   e_rs, e_rt;
    logic          b_rs, b_rt;
    ref_operand(bus.id_rs_used, bus.id_rs_addr, bus.rf_rs_data, e_rs_sel, e_rs, b_rs);
    ref_operand(bus.id_rt_used, bus.id_rt_addr, bus.rf_rt_data, e_rt_sel, e_rt, b_rt);
    chk("model_rs_data", bus.rs_data, e_rs);
    chk("model_rt_data", bus.rt_data, e_rt);
    chk("model_rs_sel", 32'(bus.fwd_rs_sel), 32'(e_rs_sel));
    chk("model_rt_sel", 32'(bus.fwd_rt_sel), 32'(e_rt_sel));
    chk("model_stall", 32'(bus.stall), 32'(bus.id_valid && (b_rs || b_rt)));
    chk("model_stall_cnt", bus.stall_cnt, m_cnt);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0;
    bus.id_we = 1'b0; bus.id_is_load = 1'b0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic ld);
    idle();
    bus.id_valid = 1'b1; bus.id_we = 1'b1; bus.id_waddr = wa; bus.id_is_load = ld;
  endtask

  task automatic read_rs(input logic [4:0] a);
    idle();
    bus.id_valid = 1'b1; bus.id_rs_used = 1'b1; bus.id_rs_addr = a;
  endtask

  task automatic read_rt(input logic [4:0] a);
    idle();
    bus.id_valid = 1'b1; bus.id_rt_used = 1'b1; bus.id_rt_addr = a;
  endtask

  initial begin
    bus.hold = 1'b0; bus.flush = 1'b0;
    bus.id_rs_addr = 5'd3; bus.id_rt_addr = 5'd4; bus.id_waddr = '0;
    bus.rf_rs_data = 32'h1111_0000; bus.rf_rt_data = 32'h2222_0000;
    bus.stage_data = {32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};
    read_rs(5'd3);
    #2;
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_rs_sel", 32'(bus.fwd_rs_sel), 32'd0);
    chk("reset_rs_data", bus.rs_data, 32'h1111_0000);
    chk("reset_cnt", bus.stall_cnt, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle();

    // ALU producer in EX forwards with sel=1.
    step(); issue(5'd3, 1'b0);
    step(); read_rs(5'd3); bus.stage_data[0 +: 32] = 32'h0000_1234; #1;
    chk("t1_rs_data", bus.rs_data, 32'h0000_1234);
    chk("t1_rs_sel", 32'(bus.fwd_rs_sel), 32'd1);
    chk("t1_stall", 32'(bus.stall), 32'd0);

    // Load-use: one stall cycle, then forward from MEM.
    issue(5'd5, 1'b1);
    step(); read_rt(5'd5); bus.stage_data[32 +: 32] = 32'h0000_BEEF; #1;
    chk("t2_stall", 32'(bus.stall), 32'd1);
    chk("t2_cnt_before", bus.stall_cnt, 32'd0);
    step();
    chk("t2_stall_after", 32'(bus.stall), 32'd0);
    chk("t2_rt_sel", 32'(bus.fwd_rt_sel), 32'd2);
    chk("t2_rt_data", bus.rt_data, 32'h0000_BEEF);
    chk("t2_cnt", bus.stall_cnt, 32'd1);

    // Writes to $0 are never tracked.
    issue(5'd0, 1'b0);
    step(); read_rs(5'd0); bus.rf_rs_data = 32'h0000_5555; #1;
    chk("t3_rs_sel", 32'(bus.fwd_rs_sel), 32'd0);
    chk("t3_rs_data", bus.rs_data, 32'h0000_5555);
    chk("t3_stall", 32'(bus.stall), 32'd0);

    // Two writers of $7: the younger wins; a younger unready load stalls.
    issue(5'd7, 1'b0); step(); issue(5'd7, 1'b0); step();
    read_rs(5'd7);
    bus.stage_data[0 +: 32] = 32'h0000_000A; bus.stage_data[32 +: 32] = 32'h0000_000B; #1;
    chk("t4_rs_data", bus.rs_data, 32'h0000_000A);
    chk("t4_rs_sel", 32'(bus.fwd_rs_sel), 32'd1);
    issue(5'd7, 1'b1); step(); read_rs(5'd7); #1;
    chk("t4_load_stall", 32'(bus.stall), 32'd1);
    idle();

    // Hold during a load-use stall freezes everything.
    issue(5'd9, 1'b1); step(); read_rs(5'd9); bus.hold = 1'b1; #1;
    chk("t5_stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_stall", 32'(bus.stall), 32'd1);
      chk("t5_hold_sel", 32'(bus.fwd_rs_sel), 32'd1);
      chk("t5_hold_cnt", bus.stall_cnt, 32'd1);
    end
    bus.hold = 1'b0;
    step();
    chk("t5_release_stall", 32'(bus.stall), 32'd0);
    chk("t5_release_sel", 32'(bus.fwd_rs_sel), 32'd2);
    chk("t5_release_cnt", bus.stall_cnt, 32'd2);

    // Asynchronous reset between edges with three writers in flight.
    issue(5'd10, 1'b0); step(); issue(5'd11, 1'b0); step(); issue(5'd12, 1'b1); step();
    read_rs(5'd12); bus.rf_rs_data = 32'h0000_7777; #1;
    chk("t6_stall_pre", 32'(bus.stall), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_stall", 32'(bus.stall), 32'd0);
    chk("t6_rst_sel", 32'(bus.fwd_rs_sel), 32'd0);
    chk("t6_rst_cnt", bus.stall_cnt, 32'd0);
    chk("t6_rst_data", bus.rs_data, 32'h0000_7777);
    @(negedge clk); rst_n = 1'b1;
    step(); read_rs(5'd11); #1;
    chk("t6_after_sel", 32'(bus.fwd_rs_sel), 32'd0);
    chk("t6_after_data", bus.rs_data, 32'h0000_7777);

    // Randomised traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.hold       = ($urandom_range(0, 9) == 0);
      bus.flush      = ($urandom_range(0, 11) == 0);
      bus.id_valid   = ($urandom_range(0, 9) < 8);
      bus.id_rs_addr = 5'($urandom_range(0, 7));
      bus.id_rt_addr = 5'($urandom_range(0, 7));
      bus.id_rs_used = 1'($urandom);
      bus.id_rt_used = 1'($urandom);
      bus.id_we      = ($urandom_range(0, 3) != 0);
      bus.id_waddr   = 5'($urandom_range(0, 7));
      bus.id_is_load = ($urandom_range(0, 2) == 0);
      bus.rf_rs_data = $urandom;
      bus.rf_rt_data = $urandom;
      for (int k = 0; k < NS; k++) bus.stage_data[k*DW +: DW] = $urandom;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
    end

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
